// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with run-time divisor updates
// applied at period boundaries and a global phase-align pulse.
module clk_div_multi #(
    parameter  int          CHANNELS    = 4,
    parameter  int          DIV_W       = 32,
    parameter  int unsigned DEFAULT_DIV = 100_000_000,
    localparam int          CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [DIV_W-1:0]    wr_div,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pend
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    // Number of cycles the divided clock stays high: ceil(d/2).
    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
        return d - (d >> 1);
    endfunction

    // Last count of the current period; only meaningful while d >= 1.
    function automatic logic [DIV_W-1:0] last_cnt(input logic [DIV_W-1:0] d);
        return d - DIV_W'(1);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DIV_W-1:0] cnt_p1;
        logic [DIV_W-1:0] div_p1;
        logic [DIV_W-1:0] pdiv_p1;
        logic             pend_p1;
        logic             clk_p1;
        logic             tick_p1;

        logic             wr_hit;
        logic             stopped;
        logic             at_end;
        logic             boundary;

        always_comb begin
            wr_hit   = wr_en && (wr_ch == CH_W'(c));
            stopped  = !en[c] || (div_p1 == '0);
            at_end   = (cnt_p1 == last_cnt(div_p1));
            boundary = stopped || sync || at_end;
        end

        // The pending value is plain data: pend qualifies it.
        always_ff @(posedge clock_in) begin
            if (wr_hit) begin
                pdiv_p1 <= wr_div;
            end
        end

        // Apply uses the pending state from before this edge, so a write
        // landing on a boundary waits for the next one.
        always_ff @(posedge clock_in) begin
            if (reset) begin
                cnt_p1  <= '0;
                div_p1  <= RESET_DIV;
                pend_p1 <= 1'b0;
                clk_p1  <= 1'b0;
                tick_p1 <= 1'b0;
            end else begin
                if (pend_p1 && boundary) begin
                    div_p1  <= pdiv_p1;
                    pend_p1 <= 1'b0;
                end
                if (wr_hit) begin
                    pend_p1 <= 1'b1;
                end

                if (stopped) begin
                    cnt_p1  <= '0;
                    clk_p1  <= 1'b0;
                    tick_p1 <= 1'b0;
                end else begin
                    tick_p1 <= (cnt_p1 == '0);
                    clk_p1  <= (cnt_p1 < high_len(div_p1));
                    if (sync || at_end) begin
                        cnt_p1 <= '0;
                    end else begin
                        cnt_p1 <= cnt_p1 + DIV_W'(1);
                    end
                end
            end
        end

        assign clock_out[c] = clk_p1;
        assign tick[c]      = tick_p1;
        assign pend[c]      = pend_p1;
    end

endmodule
